pipeline_run_ctrl: RTL

- Run-control sequencer for the 5-stage pipeline CPU. It gates the pipeline's global clock enable so the bench or a debug host can free-run, single-step, run exactly N cycles, or stop the core.
- It sits between the clock source and every pipeline register's enable input.
- It counts enabled cycles and latches a halt raised by the pipeline.

---
 rtl/run_ctrl_pkg.sv | 22 ++
 rtl/cycle_counter.sv | 35 +++
 rtl/pipeline_run_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared run-control definitions: state encoding,
// state width and default counter width.
package run_ctrl_pkg;

  localparam int STATE_W   = 3;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_RUN_N = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  function automatic logic is_running(
    input state_e s
  );
    return (s == S_RUN) || (s == S_RUN_N) || (s == S_STEP);
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Free-running enabled-cycle counter with synchronous
// clear; wraps modulo 2^W.
module cycle_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run-control sequencer gating the pipeline clock enable:
// free-run, single-step, run-N and halt handling.
module pipeline_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int STEP_LEN = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic               run_n,
  input  logic [CNT_W-1:0]   n_cycles,
  input  logic               halt_req,
  input  logic               clr_cnt,
  output logic               pipe_en,
  output logic               busy,
  output logic               halted,
  output logic               done,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   cycle_count
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] budget_q;
  logic [CNT_W-1:0] budget_d;
  logic             done_q;
  logic             done_d;
  logic             pipe_en_q;
  logic             busy_q;
  logic             halted_q;

  always_comb begin
    state_d  = state_q;
    budget_d = budget_q;
    done_d   = 1'b0;
    case (state_q)
      // HALT accepts the same commands as IDLE; a command
      // beats a still-asserted halt_req on that edge.
      S_IDLE, S_HALT: begin
        if (step) begin
          state_d  = S_STEP;
          budget_d = CNT_W'(STEP_LEN);
        end else if (run_n) begin
          if (n_cycles != '0) begin
            state_d  = S_RUN_N;
            budget_d = n_cycles;
          end else begin
            done_d = 1'b1;
          end
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_RUN_N, S_STEP: begin
        if (halt_req) begin
          state_d  = S_HALT;
          budget_d = '0;
          done_d   = 1'b1;
        end else if (stop) begin
          state_d  = S_IDLE;
          budget_d = '0;
          done_d   = 1'b1;
        end else if (budget_q == CNT_W'(1)) begin
          state_d  = S_IDLE;
          budget_d = '0;
          done_d   = 1'b1;
        end else begin
          budget_d = budget_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        budget_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      budget_q  <= '0;
      done_q    <= 1'b0;
      pipe_en_q <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      budget_q  <= budget_d;
      done_q    <= done_d;
      pipe_en_q <= is_running(state_d);
      busy_q    <= is_running(state_d);
      halted_q  <= (state_d == S_HALT);
    end
  end

  cycle_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (CLK),
    .rst   (RST),
    .en    (pipe_en_q),
    .clr   (clr_cnt),
    .count (cycle_count)
  );

  assign pipe_en = pipe_en_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule
